// File: rtl/button_conditioner.sv
// Input conditioning: synchronizes, debounces and edge-converts the push
// buttons, and stability-filters the selector/number switch banks.
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enter_raw,
    input  logic       clear_raw,
    input  logic       new_game_raw,
    input  logic [3:0] row_sel_raw,
    input  logic [3:0] col_sel_raw,
    input  logic [3:0] num_in_raw,
    output logic       enter_pulse,
    output logic       clear_pulse,
    output logic       new_game_pulse,
    output logic [3:0] row_sel,
    output logic [3:0] col_sel,
    output logic [3:0] num_in
);

    localparam int unsigned NBTN  = 3;
    localparam int unsigned NSW   = 3;
    localparam int unsigned SW_W  = 4;
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    // Press completes on the D-th high sample, release on the (D+1)-th low one.
    localparam logic [CNT_W-1:0] PRESS_LAST   = CNT_W'(DEBOUNCE_CYCLES - 2);
    localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } btn_state_e;

    logic [NBTN-1:0]           btn_raw;
    logic [NBTN-1:0]           btn_s1_q;
    logic [NBTN-1:0]           btn_s2_q;
    logic [NSW-1:0][SW_W-1:0]  sw_raw;
    logic [NSW-1:0][SW_W-1:0]  sw_s1_q;
    logic [NSW-1:0][SW_W-1:0]  sw_s2_q;
    logic [NBTN-1:0]           fire_c;
    logic [NSW-1:0][SW_W-1:0]  sw_out;

    assign btn_raw = {new_game_raw, clear_raw, enter_raw};
    assign sw_raw  = {num_in_raw, col_sel_raw, row_sel_raw};

    // Two-flop synchronizers for every raw bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_s1_q <= '0;
            btn_s2_q <= '0;
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
        end else begin
            btn_s1_q <= btn_raw;
            btn_s2_q <= btn_s1_q;
            sw_s1_q  <= sw_raw;
            sw_s2_q  <= sw_s1_q;
        end
    end

    for (genvar g = 0; g < NBTN; g++) begin : g_btn
        btn_state_e       state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             fire_d;

        // Debounce FSM state and counter registers.
        always_ff @(posedge clk) begin
            if (reset) begin
                state_q <= RELEASED;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        // Next state: accept a level only after it has been stable long enough.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            fire_d  = 1'b0;
            case (state_q)
                RELEASED: begin
                    if (btn_s2_q[g]) begin
                        cnt_d   = '0;
                        state_d = PRESS_WAIT;
                    end
                end
                PRESS_WAIT: begin
                    if (!btn_s2_q[g]) begin
                        cnt_d   = '0;
                        state_d = RELEASED;
                    end else if (cnt_q == PRESS_LAST) begin
                        cnt_d   = '0;
                        state_d = PRESSED;
                        fire_d  = 1'b1;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                PRESSED: begin
                    if (!btn_s2_q[g]) begin
                        cnt_d   = '0;
                        state_d = RELEASE_WAIT;
                    end
                end
                RELEASE_WAIT: begin
                    if (btn_s2_q[g]) begin
                        cnt_d   = '0;
                        state_d = PRESSED;
                    end else if (cnt_q == RELEASE_LAST) begin
                        cnt_d   = '0;
                        state_d = RELEASED;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = RELEASED;
                end
            endcase
        end

        assign fire_c[g] = fire_d;
    end

    // Registered strobes; a new-game press swallows simultaneous enter/clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            enter_pulse    <= 1'b0;
            clear_pulse    <= 1'b0;
            new_game_pulse <= 1'b0;
        end else begin
            enter_pulse    <= fire_c[0] & ~fire_c[2];
            clear_pulse    <= fire_c[1] & ~fire_c[2];
            new_game_pulse <= fire_c[2];
        end
    end

    for (genvar g = 0; g < NSW; g++) begin : g_sw
        logic [SW_W-1:0]  out_q, out_d;
        logic [SW_W-1:0]  cand_q, cand_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;

        // Filter output, candidate word and hold counter.
        always_ff @(posedge clk) begin
            if (reset) begin
                out_q  <= '0;
                cand_q <= '0;
                cnt_q  <= '0;
            end else begin
                out_q  <= out_d;
                cand_q <= cand_d;
                cnt_q  <= cnt_d;
            end
        end

        // Whole-word update once a differing candidate has held steady.
        always_comb begin
            out_d  = out_q;
            cand_d = cand_q;
            cnt_d  = cnt_q;
            if (sw_s2_q[g] == out_q) begin
                cand_d = out_q;
                cnt_d  = '0;
            end else if (sw_s2_q[g] != cand_q) begin
                cand_d = sw_s2_q[g];
                cnt_d  = '0;
            end else if (cnt_q == RELEASE_LAST) begin
                out_d = cand_q;
                cnt_d = '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end

        assign sw_out[g] = out_q;
    end

    assign row_sel = sw_out[0];
    assign col_sel = sw_out[1];
    assign num_in  = sw_out[2];

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: directed scenarios plus random
// stimulus compared every cycle against a run-length reference model.
module tb_button_conditioner;

    localparam int D = 4;

    logic       clk;
    logic       reset;
    logic       enter_raw, clear_raw, new_game_raw;
    logic [3:0] row_sel_raw, col_sel_raw, num_in_raw;
    logic       enter_pulse, clear_pulse, new_game_pulse;
    logic [3:0] row_sel, col_sel, num_in;

    button_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .clk            (clk),
        .reset          (reset),
        .enter_raw      (enter_raw),
        .clear_raw      (clear_raw),
        .new_game_raw   (new_game_raw),
        .row_sel_raw    (row_sel_raw),
        .col_sel_raw    (col_sel_raw),
        .num_in_raw     (num_in_raw),
        .enter_pulse    (enter_pulse),
        .clear_pulse    (clear_pulse),
        .new_game_pulse (new_game_pulse),
        .row_sel        (row_sel),
        .col_sel        (col_sel),
        .num_in         (num_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model state: raw delayed two samples, accepted levels, run lengths.
    bit       m_bd1 [3];
    bit       m_bd2 [3];
    bit       m_acc [3];
    int       m_run [3];
    bit [3:0] m_sd1 [3];
    bit [3:0] m_sd2 [3];
    bit [3:0] m_out [3];
    bit [3:0] m_rval[3];
    int       m_rlen[3];
    bit       exp_en, exp_cl, exp_ng;

    int unsigned cyc = 0;
    int unsigned n_en = 0, n_cl = 0, n_ng = 0;
    int unsigned last_en = 0, last_cl = 0, last_ng = 0;
    int unsigned row_chg = 0;
    logic [3:0]  prev_row = 4'h0;
    bit          saw7 = 1'b0;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_update();
        bit [2:0] raw_b;
        bit [3:0] raw_s [3];
        bit [2:0] fire;
        raw_b    = {new_game_raw, clear_raw, enter_raw};
        raw_s[0] = row_sel_raw;
        raw_s[1] = col_sel_raw;
        raw_s[2] = num_in_raw;
        fire     = '0;
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                m_bd1[i] = 0; m_bd2[i] = 0; m_acc[i] = 0; m_run[i] = 0;
                m_sd1[i] = 0; m_sd2[i] = 0; m_out[i] = 0; m_rval[i] = 0; m_rlen[i] = 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                // Press needs D consecutive high samples, release D+1 low samples.
                if (m_bd2[i] != m_acc[i]) begin
                    m_run[i]++;
                    if (!m_acc[i] && m_run[i] == D) begin
                        m_acc[i] = 1; m_run[i] = 0; fire[i] = 1;
                    end else if (m_acc[i] && m_run[i] == D + 1) begin
                        m_acc[i] = 0; m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
                m_bd2[i] = m_bd1[i];
                m_bd1[i] = raw_b[i];
                // A new word must be seen D+1 consecutive samples.
                if (m_sd2[i] == m_out[i]) begin
                    m_rlen[i] = 0;
                end else if (m_rlen[i] > 0 && m_sd2[i] == m_rval[i]) begin
                    m_rlen[i]++;
                end else begin
                    m_rval[i] = m_sd2[i];
                    m_rlen[i] = 1;
                end
                if (m_rlen[i] == D + 1) begin
                    m_out[i]  = m_rval[i];
                    m_rlen[i] = 0;
                end
                m_sd2[i] = m_sd1[i];
                m_sd1[i] = raw_s[i];
            end
        end
        exp_ng = fire[2];
        exp_en = fire[0] & ~fire[2];
        exp_cl = fire[1] & ~fire[2];
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_update();
        @(negedge clk);
        check("enter_pulse", enter_pulse, exp_en);
        check("clear_pulse", clear_pulse, exp_cl);
        check("new_game_pulse", new_game_pulse, exp_ng);
        check("row_sel", row_sel, m_out[0]);
        check("col_sel", col_sel, m_out[1]);
        check("num_in", num_in, m_out[2]);
        if (enter_pulse === 1'b1)    begin n_en++; last_en = cyc; end
        if (clear_pulse === 1'b1)    begin n_cl++; last_cl = cyc; end
        if (new_game_pulse === 1'b1) begin n_ng++; last_ng = cyc; end
        if (num_in === 4'h7) saw7 = 1'b1;
        if (row_sel !== prev_row) row_chg = cyc;
        prev_row = row_sel;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int unsigned k, c0, c1, c2;
        int          hold_b[3];
        int          hold_s[3];

        reset = 1'b1;
        enter_raw = 0; clear_raw = 0; new_game_raw = 0;
        row_sel_raw = 0; col_sel_raw = 0; num_in_raw = 0;
        ticks(3);
        check("reset_pulses", {enter_pulse, clear_pulse, new_game_pulse}, 0);
        check("reset_switches", {row_sel, col_sel, num_in}, 0);
        reset = 1'b0;
        ticks(10);

        // Clean press: one pulse D+1 cycles after the first high sample.
        c0 = n_en; enter_raw = 1; k = cyc + 1;
        ticks(20);
        enter_raw = 0;
        ticks(20);
        check("clean_count", n_en - c0, 1);
        check("clean_cycle", last_en, k + 5);

        // Bounce then hold: only the final rise produces a pulse.
        c0 = n_cl;
        for (int i = 0; i < 2; i++) begin
            clear_raw = 1; ticks(2);
            clear_raw = 0; ticks(2);
        end
        clear_raw = 1; k = cyc + 1;
        ticks(20);
        clear_raw = 0;
        ticks(20);
        check("bounce_count", n_cl - c0, 1);
        check("bounce_cycle", last_cl, k + 5);

        // Simultaneous enter and new_game: new_game wins, enter is consumed.
        c0 = n_en; c1 = n_ng;
        enter_raw = 1; new_game_raw = 1; k = cyc + 1;
        ticks(15);
        enter_raw = 0; new_game_raw = 0;
        ticks(20);
        check("prio_ng_count", n_ng - c1, 1);
        check("prio_ng_cycle", last_ng, k + 5);
        check("prio_en_masked", n_en - c0, 0);
        c0 = n_en; enter_raw = 1; k = cyc + 1;
        ticks(15);
        enter_raw = 0;
        ticks(20);
        check("repress_count", n_en - c0, 1);
        check("repress_cycle", last_en, k + 5);

        // Switch latency: clean step appears D+2 cycles after the first sample.
        row_sel_raw = 4'hA; k = cyc + 1;
        ticks(15);
        check("sw_latency", row_chg, k + 2 + D);
        check("sw_value", row_sel, 4'hA);

        // Short excursion to 7 must never reach the output.
        saw7 = 0;
        num_in_raw = 4'h3; ticks(2);
        num_in_raw = 4'h7; ticks(2);
        num_in_raw = 4'h3; ticks(20);
        check("sw_no_glitch", saw7, 0);
        check("sw_settled", num_in, 4'h3);

        // Reset in the middle of PRESS_WAIT restarts the debounce.
        c0 = n_en; enter_raw = 1;
        ticks(4);
        reset = 1;
        ticks(2);
        check("midreset_pulse", enter_pulse, 0);
        check("midreset_outs", {row_sel, col_sel, num_in}, 0);
        reset = 0; k = cyc + 1;
        ticks(15);
        enter_raw = 0;
        ticks(20);
        check("midreset_count", n_en - c0, 1);
        check("midreset_cycle", last_en, k + 5);

        // Long hold gives exactly one pulse.
        c2 = n_ng; new_game_raw = 1;
        ticks(100);
        new_game_raw = 0;
        ticks(20);
        check("held_count", n_ng - c2, 1);

        // Random bursts of bounces, holds, word changes and occasional reset.
        for (int i = 0; i < 3; i++) begin hold_b[i] = 0; hold_s[i] = 0; end
        for (int t = 0; t < 4000; t++) begin
            for (int i = 0; i < 3; i++) begin
                if (hold_b[i] == 0) begin
                    hold_b[i] = int'($urandom_range(1, 14));
                    case (i)
                        0: enter_raw    = ~enter_raw;
                        1: clear_raw    = ~clear_raw;
                        default: new_game_raw = ~new_game_raw;
                    endcase
                end else begin
                    hold_b[i]--;
                end
                if (hold_s[i] == 0) begin
                    hold_s[i] = int'($urandom_range(1, 10));
                    case (i)
                        0: row_sel_raw = 4'($urandom_range(0, 15));
                        1: col_sel_raw = 4'($urandom_range(0, 15));
                        default: num_in_raw = 4'($urandom_range(0, 15));
                    endcase
                end else begin
                    hold_s[i]--;
                end
            end
            reset = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 0;
        ticks(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
